// File: rtl/qp_doorbell_tracker.sv
// Per-QP pending-WQE tracker: counts doorbelled WQEs per queue pair and runs one
// arbitrate / grant / issue handshake at a time towards the WQE read scheduler.
module qp_doorbell_tracker #(
    parameter int unsigned MAX_QP       = 256,
    parameter int unsigned QP_PTR_WIDTH = $clog2(MAX_QP),
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic                    i_db_val,
    input  logic [QP_PTR_WIDTH-1:0] i_db_qp_idx,
    input  logic [CNT_WIDTH-1:0]    i_db_num,
    output logic                    o_arbit,
    output logic [MAX_QP-1:0]       o_active,
    input  logic                    i_arbit_val,
    input  logic [QP_PTR_WIDTH-1:0] i_qp_idx,
    output logic                    o_wqe_rd_val,
    output logic [QP_PTR_WIDTH-1:0] o_wqe_rd_qp_idx,
    input  logic                    i_wqe_rd_rdy,
    output logic                    o_err_ovf,
    output logic                    o_err_spur
);

    localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;
    localparam int unsigned IDX_WIDTH = QP_PTR_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0] QP_LIMIT = IDX_WIDTH'(MAX_QP);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = '1;
    localparam logic [SUM_WIDTH-1:0] SUM_SAT  = {1'b0, CNT_SAT};

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_WIDTH-1:0]    cnt [MAX_QP];
    logic [MAX_QP-1:0]       active_c;

    logic [IDX_WIDTH-1:0]    db_idx_ext;
    logic [IDX_WIDTH-1:0]    gr_idx_ext;
    logic                    db_en;
    logic                    grant_ok;
    logic                    grant_hit_db;
    logic [SUM_WIDTH-1:0]    db_sum;
    logic [CNT_WIDTH-1:0]    db_next;
    logic                    ovf_c;
    logic                    spur_c;

    logic                    arbit_nxt;
    logic                    rd_val_nxt;
    logic [QP_PTR_WIDTH-1:0] rd_idx_nxt;

    // Doorbell add, grant decrement and saturation; a doorbell and a grant to the
    // same QP fold into a single cnt + num - 1 update.
    always_comb begin
        db_idx_ext   = {1'b0, i_db_qp_idx};
        gr_idx_ext   = {1'b0, i_qp_idx};
        db_en        = i_db_val && (db_idx_ext < QP_LIMIT);
        grant_ok     = (state == WAIT) && i_arbit_val && (gr_idx_ext < QP_LIMIT)
                       && (cnt[i_qp_idx] != '0);
        grant_hit_db = grant_ok && (i_qp_idx == i_db_qp_idx);
        db_sum       = {1'b0, cnt[i_db_qp_idx]} + {1'b0, i_db_num} - SUM_WIDTH'(grant_hit_db);
        ovf_c        = db_en && (db_sum > SUM_SAT);
        db_next      = ovf_c ? CNT_SAT : db_sum[CNT_WIDTH-1:0];
        spur_c       = (i_arbit_val && !grant_ok) || (i_db_val && !db_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '{default: '0};
        end else begin
            if (grant_ok) begin
                cnt[i_qp_idx] <= cnt[i_qp_idx] - CNT_WIDTH'(1);
            end
            if (db_en) begin
                cnt[i_db_qp_idx] <= db_next;
            end
        end
    end

    for (genvar q = 0; q < MAX_QP; q++) begin : g_active
        assign active_c[q] = (cnt[q] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_active <= '0;
        end else begin
            o_active <= active_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // One request in flight; ISSUE always returns through IDLE before the next REQ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_enable && (|o_active)) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    if (i_arbit_val) state_nxt = grant_ok ? ISSUE : IDLE;
            ISSUE:   if (i_wqe_rd_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        arbit_nxt  = (state_nxt == REQ);
        rd_val_nxt = (state_nxt == ISSUE);
        rd_idx_nxt = o_wqe_rd_qp_idx;
        if (grant_ok) begin
            rd_idx_nxt = i_qp_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_arbit         <= 1'b0;
            o_wqe_rd_val    <= 1'b0;
            o_wqe_rd_qp_idx <= '0;
            o_err_ovf       <= 1'b0;
            o_err_spur      <= 1'b0;
        end else begin
            o_arbit         <= arbit_nxt;
            o_wqe_rd_val    <= rd_val_nxt;
            o_wqe_rd_qp_idx <= rd_idx_nxt;
            o_err_ovf       <= ovf_c;
            o_err_spur      <= spur_c;
        end
    end

endmodule

// File: tb/tb_qp_doorbell_tracker.sv
// Scoreboard bench for qp_doorbell_tracker: directed doorbell/grant scenarios queue
// their expected output events; a negedge monitor pops and compares them.
module tb_qp_doorbell_tracker;

    localparam int unsigned MAX_QP = 256;
    localparam int unsigned QPW    = 8;
    localparam int unsigned CW     = 16;

    localparam int EV_ARB  = 0;
    localparam int EV_RD   = 1;
    localparam int EV_OVF  = 2;
    localparam int EV_SPUR = 3;

    typedef struct {
        int kind;
        int idx;
    } evt_t;

    logic              clk;
    logic              rst;
    logic              i_enable;
    logic              i_db_val;
    logic [QPW-1:0]    i_db_qp_idx;
    logic [CW-1:0]     i_db_num;
    logic              o_arbit;
    logic [MAX_QP-1:0] o_active;
    logic              i_arbit_val;
    logic [QPW-1:0]    i_qp_idx;
    logic              o_wqe_rd_val;
    logic [QPW-1:0]    o_wqe_rd_qp_idx;
    logic              i_wqe_rd_rdy;
    logic              o_err_ovf;
    logic              o_err_spur;

    evt_t exp_q[$];
    int   n_total;
    int   n_pass;

    qp_doorbell_tracker #(.MAX_QP(MAX_QP), .QP_PTR_WIDTH(QPW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (i_enable),
        .i_db_val        (i_db_val),
        .i_db_qp_idx     (i_db_qp_idx),
        .i_db_num        (i_db_num),
        .o_arbit         (o_arbit),
        .o_active        (o_active),
        .i_arbit_val     (i_arbit_val),
        .i_qp_idx        (i_qp_idx),
        .o_wqe_rd_val    (o_wqe_rd_val),
        .o_wqe_rd_qp_idx (o_wqe_rd_qp_idx),
        .i_wqe_rd_rdy    (i_wqe_rd_rdy),
        .o_err_ovf       (o_err_ovf),
        .o_err_spur      (o_err_spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kind_name(input int k);
        case (k)
            EV_ARB:  return "arbit";
            EV_RD:   return "rd";
            EV_OVF:  return "ovf";
            default: return "spur";
        endcase
    endfunction

    task automatic push(input int kind, input int idx);
        evt_t e;
        e.kind = kind;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    task automatic match_evt(input int kind, input int idx);
        evt_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL evt: got unexpected %s idx %0d at %0t, required none",
                     kind_name(kind), idx, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.idx == idx) n_pass++;
            else $display("FAIL evt: got %s idx %0d at %0t, required %s idx %0d",
                          kind_name(kind), idx, $time, kind_name(e.kind), e.idx);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; fixed per-cycle event order.
    initial begin
        forever begin
            @(negedge clk);
            if (o_arbit)                      match_evt(EV_ARB, 0);
            if (o_wqe_rd_val && i_wqe_rd_rdy) match_evt(EV_RD, int'(o_wqe_rd_qp_idx));
            if (o_err_ovf)                    match_evt(EV_OVF, 0);
            if (o_err_spur)                   match_evt(EV_SPUR, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic db_pulse(input int qp, input int num);
        i_db_val    = 1'b1;
        i_db_qp_idx = QPW'(qp);
        i_db_num    = CW'(num);
        tick();
        i_db_val    = 1'b0;
    endtask

    task automatic wait_arb(input string name);
        int n;
        n = 0;
        while (!o_arbit && n < 20) begin
            tick();
            n++;
        end
        n_total++;
        if (o_arbit) n_pass++;
        else $display("FAIL %s: got no o_arbit within 20 cycles, required a pulse", name);
    endtask

    // Answer the next o_arbit with a grant; optionally a doorbell lands on the grant edge.
    task automatic serve(input int qp, input bit with_db, input int db_num);
        wait_arb("serve_arb");
        tick();
        i_arbit_val = 1'b1;
        i_qp_idx    = QPW'(qp);
        if (with_db) begin
            i_db_val    = 1'b1;
            i_db_qp_idx = QPW'(qp);
            i_db_num    = CW'(db_num);
        end
        tick();
        i_arbit_val = 1'b0;
        i_db_val    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drained(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b1;
        i_enable    = 1'b0;
        i_db_val    = 1'b0;
        i_db_qp_idx = '0;
        i_db_num    = '0;
        i_arbit_val = 1'b0;
        i_qp_idx    = '0;
        i_wqe_rd_rdy = 1'b0;
        idle(3);
        check("rst_arbit",  64'(o_arbit), 64'd0);
        check("rst_rd_val", 64'(o_wqe_rd_val), 64'd0);
        check("rst_rd_idx", 64'(o_wqe_rd_qp_idx), 64'd0);
        check("rst_ovf",    64'(o_err_ovf), 64'd0);
        check("rst_spur",   64'(o_err_spur), 64'd0);
        check("rst_active", 64'(|o_active), 64'd0);
        rst = 1'b0;
        i_enable     = 1'b1;
        i_wqe_rd_rdy = 1'b1;
        tick();

        // Two WQEs on QP 3 drained by two grants.
        push(EV_ARB, 0); push(EV_RD, 3); push(EV_ARB, 0); push(EV_RD, 3);
        db_pulse(3, 2);
        serve(3, 1'b0, 0);
        serve(3, 1'b0, 0);
        check("q3_active_at_grant", 64'(o_active[3]), 64'd1);
        tick();
        check("q3_active_cleared", 64'(o_active[3]), 64'd0);
        idle(8);
        drained("q3_drained");

        // Doorbell of 4 on the grant edge for QP 5 holding 1 -> 4 pending.
        push(EV_ARB, 0); push(EV_RD, 5);
        for (int i = 0; i < 4; i++) begin
            push(EV_ARB, 0); push(EV_RD, 5);
        end
        db_pulse(5, 1);
        serve(5, 1'b1, 4);
        check("q5_active_grant", 64'(o_active[5]), 64'd1);
        tick();
        check("q5_active_after", 64'(o_active[5]), 64'd1);
        for (int i = 0; i < 4; i++) serve(5, 1'b0, 0);
        check("q5_active_last", 64'(o_active[5]), 64'd1);
        tick();
        check("q5_active_cleared", 64'(o_active[5]), 64'd0);
        idle(8);
        drained("q5_drained");

        // Saturation: 65534+1 lands exactly on max, then +5 saturates.
        i_enable = 1'b0;
        db_pulse(7, 65534);
        db_pulse(7, 1);
        idle(3);
        push(EV_OVF, 0);
        db_pulse(7, 5);
        idle(3);
        drained("ovf_drained");
        i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(EV_ARB, 0); push(EV_RD, 7);
        end
        for (int i = 0; i < 4; i++) serve(7, 1'b0, 0);
        tick();
        check("q7_saturated_active", 64'(o_active[7]), 64'd1);
        do_reset();
        check("q7_reset_active", 64'(|o_active), 64'd0);
        idle(3);
        drained("q7_drained");

        // Grant while IDLE, then grant to an empty QP while WAIT.
        push(EV_SPUR, 0);
        i_arbit_val = 1'b1;
        i_qp_idx    = QPW'(2);
        tick();
        i_arbit_val = 1'b0;
        check("idle_grant_no_rd", 64'(o_wqe_rd_val), 64'd0);
        idle(2);
        push(EV_ARB, 0); push(EV_SPUR, 0); push(EV_ARB, 0); push(EV_RD, 4);
        db_pulse(4, 1);
        serve(6, 1'b0, 0);
        check("spur_wait_no_rd", 64'(o_wqe_rd_val), 64'd0);
        check("spur_q6_active", 64'(o_active[6]), 64'd0);
        serve(4, 1'b0, 0);
        tick();
        check("q4_active_cleared", 64'(o_active[4]), 64'd0);
        idle(6);
        drained("spur_drained");

        // Fetch engine stalls for 10 cycles in ISSUE.
        push(EV_ARB, 0); push(EV_RD, 10); push(EV_ARB, 0); push(EV_RD, 10);
        i_wqe_rd_rdy = 1'b0;
        db_pulse(10, 2);
        serve(10, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            check("stall_rd_val", 64'(o_wqe_rd_val), 64'd1);
            check("stall_rd_idx", 64'(o_wqe_rd_qp_idx), 64'd10);
            check("stall_no_arbit", 64'(o_arbit), 64'd0);
            tick();
        end
        i_wqe_rd_rdy = 1'b1;
        tick();
        serve(10, 1'b0, 0);
        idle(6);
        check("q10_active_cleared", 64'(o_active[10]), 64'd0);
        drained("stall_drained");

        // Asynchronous reset while a read command is pending.
        push(EV_ARB, 0);
        i_wqe_rd_rdy = 1'b0;
        db_pulse(9, 3);
        serve(9, 1'b0, 0);
        idle(2);
        check("pre_rst_rd_val", 64'(o_wqe_rd_val), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rd_val", 64'(o_wqe_rd_val), 64'd0);
        check("async_rd_idx", 64'(o_wqe_rd_qp_idx), 64'd0);
        check("async_arbit",  64'(o_arbit), 64'd0);
        check("async_active", 64'(|o_active), 64'd0);
        check("async_errs",   64'(o_err_ovf | o_err_spur), 64'd0);
        tick();
        rst = 1'b0;
        i_wqe_rd_rdy = 1'b1;
        idle(10);
        check("post_rst_active", 64'(|o_active), 64'd0);
        push(EV_SPUR, 0);
        i_arbit_val = 1'b1;
        i_qp_idx    = QPW'(9);
        tick();
        i_arbit_val = 1'b0;
        idle(2);
        push(EV_ARB, 0); push(EV_RD, 9);
        db_pulse(9, 1);
        serve(9, 1'b0, 0);
        idle(6);
        check("q9_active_cleared", 64'(o_active[9]), 64'd0);
        drained("final_drained");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
